mx_alu_ingress_arb: RTL
=======================

Name: mx_alu_ingress_arb

Overview:
Multi-channel ingress stage in front of the MX ALU. It accepts MX requests (dtype, op, scalar, vec_a, vec_b) from nch independent producers over valid/ready handshakes. Each channel gets a 2-entry skid buffer; a round-robin arbiter merges the channels into one registered valid/ready issue port tagged with the channel id. Requests with an illegal dtype are dropped, and an error pulse plus a saturating counter report each drop.

Parameters:
d, 8, element width in bits
k, 32, elements per MX block
w, 8, shared-scale width in bits
s, 32, scalar operand width
nch, 4, number of input channels (>=1)
size (localparam), w+k*d, packed MX vector width
cw (localparam), max(1,$clog2(nch)), channel-id width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  nch  per-channel request valid
in_ready  out  nch  per-channel ready
in_dtype  in  3*nch  per-channel dtype, packed, channel 0 in LSBs
in_op  in  3*nch  per-channel op code
in_scalar  in  s*nch  per-channel scalar
in_vec_a  in  size*nch  per-channel vector A
in_vec_b  in  size*nch  per-channel vector B
out_valid  out  1  issue valid
out_ready  in  1  ALU ready
out_ch  out  cw  source channel of the issued request
out_dtype  out  3  issued dtype
out_op  out  3  issued op
out_scalar  out  s  issued scalar
out_vec_a  out  size  issued vector A
out_vec_b  out  size  issued vector B
err_pulse  out  1  one-cycle pulse: illegal request dropped
err_ch  out  cw  lowest channel index dropped in that cycle
err_count  out  16  saturating count of dropped requests

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Outputs during reset: every output is 0, including in_ready. A ready-enable flop sets on the first clk edge after rst_n deasserts; only then can in_ready go high.
- Reset mid-operation: all buffered and in-flight requests are discarded, err_count clears and the grant pointer returns to channel 0.
- Handshake: a transfer occurs when valid && ready at a rising edge.
  - in_ready[i] = ready_en && (count_i < 2), decoded from registered state only. There is no combinational path from out_ready or in_valid to in_ready.
  - Push and pop on the same channel in the same cycle with count==1 leaves count at 1.
- dtype legality: 0..5 are legal (E4M3, E5M2, E3M2, E2M3, E2M1, INT8); 6 and 7 are illegal.
  - An illegal request is accepted (ready honoured) but not stored.
  - Next cycle: err_pulse=1 and err_ch = lowest offending channel.
  - err_count adds the popcount of illegal accepts in that cycle and saturates at 0xFFFF.
- op is passed through unchecked.
- Output stage: a single register.
  - It loads when empty or when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* fields hold stable and out_valid stays high.
- Arbitration: round-robin over channels with a non-empty buffer, starting at the grant pointer.
  - On a load, the pointer moves to winner+1, wrapping nch-1 -> 0.
  - The pointer does not move when no load happens.
- Latency and throughput:
  - A request accepted at edge t appears on out_valid after edge t+1, i.e. a 2-edge minimum.
  - Sustained throughput is 1 request per cycle with out_ready=1.
  - Per-channel order is preserved; there is no ordering between channels.
- Capacity: with out_ready=0, each channel holds 2 requests in its buffer. One additional request, from the arbitration winner, sits in the output register.
- nch=1: the arbiter degenerates and out_ch is always 0.

Decomposition:
- Package mx_alu_pkg:
  - dtype_e enum (3-bit, values 0..5 as above)
  - op_e enum (3-bit)
  - function dtype_legal()
  - req_t struct template fields (dtype, op, scalar, vec_a, vec_b); sized via parameters at instantiation
- Sub-module mx_skid_buf2: 2-entry FIFO with count, push/pop and head output. Instantiated nch times.
- The round-robin arbiter and the output register stay in the top.

Test Plan:
1. Reset: assert rst_n low mid-traffic with 2 entries buffered -> all outputs 0 asynchronously. After release, in_ready=4'b0000 until the first edge, then 4'b1111; no stale request ever issues.
2. Single channel: ch0 pushes dtype=0, op=1, scalar=0x12345678 at edge t with out_ready=1 -> out_valid high after t+1, out_ch=0, payload bit-exact. Then 8 back-to-back pushes -> 8 consecutive out_valid cycles, in order.
3. Fairness: all 4 channels continuously valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,...; over 40 issues, each channel gets exactly 10.
4. Backpressure: out_ready=0 for 10 cycles while ch1 pushes every cycle -> exactly 3 accepted, then in_ready[1]=0 and out_* stable throughout. Raise out_ready -> 3 issues in push order, then 1 per cycle.
5. Illegal dtype: same cycle, ch2 dtype=6 and ch3 dtype=7, ch0 dtype=5 -> only ch0 issues; err_pulse=1 for one cycle, err_ch=2, err_count+=2.
6. Saturation and mixed events: drive 65540 illegal requests -> err_count holds at 0xFFFF. A legal push and a pop on ch0 with count==1 in the same cycle -> count stays 1 and in_ready[0] stays 1.

Source files
------------

// File: rtl/mx_alu_ingress_arb_pkg.sv
// Shared types for the MX ALU ingress path: dtype/op encodings, legality check
// and a default-sized request record.
package mx_alu_pkg;

    typedef enum logic [2:0] {
        DT_E4M3 = 3'd0,
        DT_E5M2 = 3'd1,
        DT_E3M2 = 3'd2,
        DT_E2M3 = 3'd3,
        DT_E2M1 = 3'd4,
        DT_INT8 = 3'd5
    } dtype_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_FMA = 3'd3,
        OP_MAX = 3'd4,
        OP_MIN = 3'd5,
        OP_DOT = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    localparam int DEF_D    = 8;
    localparam int DEF_K    = 32;
    localparam int DEF_W    = 8;
    localparam int DEF_S    = 32;
    localparam int DEF_SIZE = DEF_W + DEF_K * DEF_D;

    // Field template; the top re-declares it at its own parameter sizes.
    typedef struct packed {
        logic [2:0]          dtype;
        logic [2:0]          op;
        logic [DEF_S-1:0]    scalar;
        logic [DEF_SIZE-1:0] vec_a;
        logic [DEF_SIZE-1:0] vec_b;
    } req_t;

    function automatic logic dtype_legal(input logic [2:0] dt);
        return (dt <= 3'(DT_INT8));
    endfunction

endpackage

// File: rtl/mx_alu_ingress_arb_if.sv
// Bundle of per-channel request inputs, the issue port and the drop reporting.
// slave = the arbiter, master = producers plus the ALU side.
interface mx_alu_ingress_arb_if #(
    parameter int D   = 8,
    parameter int K   = 32,
    parameter int W   = 8,
    parameter int S   = 32,
    parameter int NCH = 4
);
    localparam int SIZE = W + K * D;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    // Transfer on a channel or on the issue port when valid && ready at a rising clk edge.
    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [3*NCH-1:0]    in_dtype;
    logic [3*NCH-1:0]    in_op;
    logic [S*NCH-1:0]    in_scalar;
    logic [SIZE*NCH-1:0] in_vec_a;
    logic [SIZE*NCH-1:0] in_vec_b;
    logic                out_valid;
    logic                out_ready;
    logic [CW-1:0]       out_ch;
    logic [2:0]          out_dtype;
    logic [2:0]          out_op;
    logic [S-1:0]        out_scalar;
    logic [SIZE-1:0]     out_vec_a;
    logic [SIZE-1:0]     out_vec_b;
    logic                err_pulse;
    logic [CW-1:0]       err_ch;
    logic [15:0]         err_count;

    modport master (
        output in_valid, in_dtype, in_op, in_scalar, in_vec_a, in_vec_b, out_ready,
        input  in_ready, out_valid, out_ch, out_dtype, out_op, out_scalar,
        input  out_vec_a, out_vec_b, err_pulse, err_ch, err_count
    );

    modport slave (
        input  in_valid, in_dtype, in_op, in_scalar, in_vec_a, in_vec_b, out_ready,
        output in_ready, out_valid, out_ch, out_dtype, out_op, out_scalar,
        output out_vec_a, out_vec_b, err_pulse, err_ch, err_count
    );

endinterface

// File: rtl/mx_skid_buf2.sv
// Two-entry FIFO with occupancy count; head_o is the oldest entry.
module mx_skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic [1:0]            cnt_q, cnt_d;

    // Pop is applied first so a push lands in the slot the pop left behind.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop_i && (cnt_q != 2'd0)) begin
            mem_d[0] = mem_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        if (push_i && (cnt_q != 2'd2)) begin
            if (cnt_d == 2'd0) mem_d[0] = data_i;
            else               mem_d[1] = data_i;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/mx_alu_ingress_arb.sv
// Per-channel skid buffers merged by a round-robin arbiter into a registered
// issue port; illegal-dtype requests are swallowed and reported.
module mx_alu_ingress_arb
    import mx_alu_pkg::*;
#(
    parameter int D   = 8,
    parameter int K   = 32,
    parameter int W   = 8,
    parameter int S   = 32,
    parameter int NCH = 4
) (
    input logic               clk,
    input logic               rst_n,
    mx_alu_ingress_arb_if.slave ifc
);

    localparam int SIZE = W + K * D;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [2:0]      dtype;
        logic [2:0]      op;
        logic [S-1:0]    scalar;
        logic [SIZE-1:0] vec_a;
        logic [SIZE-1:0] vec_b;
    } req_t;

    localparam int RW = $bits(req_t);

    logic           ready_en_q;
    req_t           req_in [NCH];
    req_t           head   [NCH];
    logic [1:0]     cnt    [NCH];
    logic [NCH-1:0] rdy, acc, push, ill, pop, nonempty;

    always_comb begin
        rdy      = '0;
        acc      = '0;
        push     = '0;
        ill      = '0;
        nonempty = '0;
        for (int i = 0; i < NCH; i++) begin
            rdy[i]      = ready_en_q && (cnt[i] != 2'd2);
            acc[i]      = ifc.in_valid[i] && rdy[i];
            push[i]     = acc[i] && dtype_legal(ifc.in_dtype[3*i +: 3]);
            ill[i]      = acc[i] && !dtype_legal(ifc.in_dtype[3*i +: 3]);
            nonempty[i] = (cnt[i] != 2'd0);
            req_in[i]   = {ifc.in_dtype[3*i +: 3], ifc.in_op[3*i +: 3], ifc.in_scalar[S*i +: S],
                           ifc.in_vec_a[SIZE*i +: SIZE], ifc.in_vec_b[SIZE*i +: SIZE]};
        end
    end

    assign ifc.in_ready = rdy;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mx_skid_buf2 #(.WIDTH(RW)) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (req_in[g]),
            .head_o  (head[g]),
            .count_o (cnt[g])
        );
    end

    logic          out_valid_q;
    req_t          out_q;
    logic [CW-1:0] out_ch_q, ptr_q, ptr_d, win, cand;
    logic          load, found;
    int            idx;

    assign load = !out_valid_q || ifc.out_ready;

    // Scan starts at the grant pointer; the first non-empty channel wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        pop   = '0;
        ptr_d = ptr_q;
        for (int off = 0; off < NCH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NCH) idx = idx - NCH;
            cand = CW'(idx);
            if (!found && nonempty[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (load && found) begin
            pop[win] = 1'b1;
            ptr_d    = (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (load) begin
                out_valid_q <= found;
                ptr_q       <= ptr_d;
                if (found) begin
                    out_q    <= head[win];
                    out_ch_q <= win;
                end
            end
        end
    end

    logic          err_pulse_q;
    logic [CW-1:0] err_ch_q, err_ch_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [31:0]   ill_cnt, err_sum;

    always_comb begin
        err_ch_d = '0;
        ill_cnt  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ill[i]) err_ch_d = CW'(i);
        end
        for (int i = 0; i < NCH; i++) begin
            ill_cnt = ill_cnt + 32'(ill[i]);
        end
        err_sum     = 32'(err_count_q) + ill_cnt;
        err_count_d = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_ch_q    <= '0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= |ill;
            err_ch_q    <= err_ch_d;
            err_count_q <= err_count_d;
        end
    end

    assign ifc.out_valid  = out_valid_q;
    assign ifc.out_ch     = out_ch_q;
    assign ifc.out_dtype  = out_q.dtype;
    assign ifc.out_op     = out_q.op;
    assign ifc.out_scalar = out_q.scalar;
    assign ifc.out_vec_a  = out_q.vec_a;
    assign ifc.out_vec_b  = out_q.vec_b;
    assign ifc.err_pulse  = err_pulse_q;
    assign ifc.err_ch     = err_ch_q;
    assign ifc.err_count  = err_count_q;

endmodule
